// File: rtl/sorcerer_ram_arbiter_if.sv
// Bundle of all requester and RAM-side signals of the Sorcerer main-RAM arbiter.
// The slave modport is the arbiter's view; the master modport is the system side.
interface sorcerer_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              dl_active;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [DATA_W-1:0] dl_data;
    logic              dl_wait;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_valid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data,
        input  vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output dl_wait,
        output vid_ack, vid_valid, vid_rdata,
        output cpu_ack, cpu_valid, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output dl_active, dl_wr, dl_addr, dl_data,
        output vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  dl_wait,
        input  vid_ack, vid_valid, vid_rdata,
        input  cpu_ack, cpu_valid, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sorcerer_ram_arbiter.sv
// Single-port RAM arbiter: download writes first, then video/CPU alternating,
// with read data routed back through a 2-stage requester tag pipeline.
module sorcerer_ram_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input logic                   clk_sys,
    input logic                   reset,
    sorcerer_ram_arbiter_if.slave bus
);
    localparam logic GNT_VID = 1'b0;
    localparam logic GNT_CPU = 1'b1;

    typedef struct packed {
        logic vid;
        logic cpu;
    } tag_t;

    logic              hb_full_q, hb_full_d;
    logic [ADDR_W-1:0] hb_addr_q, hb_addr_d;
    logic [DATA_W-1:0] hb_data_q, hb_data_d;
    logic              last_gnt_q, last_gnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    tag_t              tag1_q, tag1_d;
    tag_t              tag2_q, tag2_d;
    logic              vid_valid_q, vid_valid_d;
    logic              cpu_valid_q, cpu_valid_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    logic gnt_dl, gnt_vid, gnt_cpu;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_dl  = hb_full_q;
        gnt_vid = 1'b0;
        gnt_cpu = 1'b0;
        if (!hb_full_q && !bus.dl_active) begin
            if (bus.vid_req && bus.cpu_req) begin
                gnt_vid = (last_gnt_q == GNT_CPU);
                gnt_cpu = (last_gnt_q == GNT_VID);
            end else begin
                gnt_vid = bus.vid_req;
                gnt_cpu = bus.cpu_req;
            end
        end
    end

    always_comb begin
        hb_full_d   = hb_full_q;
        hb_addr_d   = hb_addr_q;
        hb_data_d   = hb_data_q;
        last_gnt_d  = last_gnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // A strobe in the drain cycle refills the buffer, so the load wins over the clear.
        if (gnt_dl) hb_full_d = 1'b0;
        if (bus.dl_wr) begin
            hb_full_d = 1'b1;
            hb_addr_d = bus.dl_addr;
            hb_data_d = bus.dl_data;
        end

        if (gnt_vid) last_gnt_d = GNT_VID;
        if (gnt_cpu) last_gnt_d = GNT_CPU;

        mem_en_d = gnt_dl | gnt_vid | gnt_cpu;
        mem_we_d = gnt_dl | (gnt_cpu & bus.cpu_we);
        if (gnt_dl) begin
            mem_addr_d  = hb_addr_q;
            mem_wdata_d = hb_data_q;
        end else if (gnt_vid) begin
            mem_addr_d  = bus.vid_addr;
        end else if (gnt_cpu) begin
            mem_addr_d  = bus.cpu_addr;
            if (bus.cpu_we) mem_wdata_d = bus.cpu_wdata;
        end

        tag1_d.vid  = gnt_vid;
        tag1_d.cpu  = gnt_cpu & ~bus.cpu_we;
        tag2_d      = tag1_q;
        vid_valid_d = tag2_q.vid;
        cpu_valid_d = tag2_q.cpu;
        vid_rdata_d = tag2_q.vid ? bus.mem_rdata : vid_rdata_q;
        cpu_rdata_d = tag2_q.cpu ? bus.mem_rdata : cpu_rdata_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hb_full_q   <= 1'b0;
            hb_addr_q   <= '0;
            hb_data_q   <= '0;
            last_gnt_q  <= GNT_CPU;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag1_q      <= '0;
            tag2_q      <= '0;
            vid_valid_q <= 1'b0;
            cpu_valid_q <= 1'b0;
            vid_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            hb_full_q   <= hb_full_d;
            hb_addr_q   <= hb_addr_d;
            hb_data_q   <= hb_data_d;
            last_gnt_q  <= last_gnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            vid_valid_q <= vid_valid_d;
            cpu_valid_q <= cpu_valid_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign bus.dl_wait   = hb_full_q;
    assign bus.vid_ack   = gnt_vid;
    assign bus.cpu_ack   = gnt_cpu;
    assign bus.vid_valid = vid_valid_q;
    assign bus.cpu_valid = cpu_valid_q;
    assign bus.vid_rdata = vid_rdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_sorcerer_ram_arbiter.sv
// Directed bench for sorcerer_ram_arbiter: synchronous RAM model, expected read data
// queued per requester at grant time and compared by a separate valid-pulse monitor.
module tb_sorcerer_ram_arbiter;
    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    sorcerer_ram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    sorcerer_ram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] vid_q[$];
    logic [7:0] cpu_q[$];
    logic [7:0] ram [0:65535];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_sys);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dl_wait"},   bus.dl_wait,   0);
        check({tag, "_vid_ack"},   bus.vid_ack,   0);
        check({tag, "_cpu_ack"},   bus.cpu_ack,   0);
        check({tag, "_vid_valid"}, bus.vid_valid, 0);
        check({tag, "_cpu_valid"}, bus.cpu_valid, 0);
        check({tag, "_mem_en"},    bus.mem_en,    0);
        check({tag, "_mem_we"},    bus.mem_we,    0);
        check({tag, "_mem_addr"},  bus.mem_addr,  0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_vid_rdata"}, bus.vid_rdata, 0);
        check({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
    endtask

    // Synchronous single-port RAM, read-before-write; contents preloaded while in reset.
    always @(posedge clk_sys) begin
        if (reset) begin
            ram[16'h1234] <= 8'h5A;
            for (int j = 0; j < 3; j++) begin
                ram[16'h2000 + j] <= 8'(8'hC0 + j);
                ram[16'h3000 + j] <= 8'(8'h30 + j);
            end
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    // Monitor: every valid pulse must match the oldest expected byte for that requester.
    always @(negedge clk_sys) begin
        if (!reset) begin
            if (bus.vid_valid) begin
                if (vid_q.size() == 0) check("vid_valid_unexpected", 1, 0);
                else                   check("vid_rdata", bus.vid_rdata, vid_q.pop_front());
            end
            if (bus.cpu_valid) begin
                if (cpu_q.size() == 0) check("cpu_valid_unexpected", 1, 0);
                else                   check("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int vj;
        int cj;
        logic exp_vid;

        bus.dl_active = 0; bus.dl_wr = 0; bus.dl_addr = '0; bus.dl_data = '0;
        bus.vid_req = 0; bus.vid_addr = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;

        // Reset, then idle for 10 cycles.
        repeat (2) smp();
        check_reset_state("rst");
        step();
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            smp();
            check($sformatf("idle_mem_en_%0d", i), bus.mem_en, 0);
            step();
        end

        // Solo CPU read of 0x1234.
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h1234;
        smp();
        check("solo_cpu_ack", bus.cpu_ack, 1);
        check("solo_vid_ack", bus.vid_ack, 0);
        cpu_q.push_back(8'h5A);
        step();
        bus.cpu_req = 0;
        smp();
        check("solo_mem_en", bus.mem_en, 1);
        check("solo_mem_we", bus.mem_we, 0);
        check("solo_mem_addr", bus.mem_addr, 16'h1234);
        step(); smp();
        check("solo_cpu_valid_c2", bus.cpu_valid, 0);
        step(); smp();
        check("solo_cpu_valid_c3", bus.cpu_valid, 1);
        check("solo_vid_valid_c3", bus.vid_valid, 0);
        step();

        // Contention: last grant was CPU, so video wins first, then strict alternation.
        vj = 0; cj = 0;
        bus.vid_req = 1; bus.vid_addr = 16'h2000;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h3000;
        for (int k = 0; k < 6; k++) begin
            smp();
            exp_vid = (k % 2 == 0);
            check($sformatf("contend_vid_ack_%0d", k), bus.vid_ack, exp_vid);
            check($sformatf("contend_cpu_ack_%0d", k), bus.cpu_ack, !exp_vid);
            if (exp_vid) begin vid_q.push_back(8'(8'hC0 + vj)); vj++; end
            else         begin cpu_q.push_back(8'(8'h30 + cj)); cj++; end
            step();
            bus.vid_addr = 16'(16'h2000 + vj);
            bus.cpu_addr = 16'(16'h3000 + cj);
            if (k == 5) begin bus.vid_req = 0; bus.cpu_req = 0; end
        end
        repeat (4) step();

        // Download burst with CPU read of 0x0002 held; dl_active drops while the buffer is still full.
        bus.dl_active = 1; bus.dl_wr = 1; bus.dl_addr = 16'h0000; bus.dl_data = 8'h10;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0002;
        for (int c = 0; c < 7; c++) begin
            smp();
            if (c < 6) begin
                check($sformatf("dl_wait_%0d", c), bus.dl_wait, (c >= 1 && c <= 4));
                check($sformatf("dl_cpu_ack_%0d", c), bus.cpu_ack, (c == 5));
                check($sformatf("dl_mem_en_%0d", c), bus.mem_en, (c >= 2));
                if (c >= 2) begin
                    check($sformatf("dl_mem_we_%0d", c), bus.mem_we, 1);
                    check($sformatf("dl_mem_addr_%0d", c), bus.mem_addr, c - 2);
                    check($sformatf("dl_mem_wdata_%0d", c), bus.mem_wdata, 8'h10 + c - 2);
                end
                if (c == 5) cpu_q.push_back(8'h12);
            end else begin
                check("dl_cpu_mem_en", bus.mem_en, 1);
                check("dl_cpu_mem_we", bus.mem_we, 0);
                check("dl_cpu_mem_addr", bus.mem_addr, 16'h0002);
            end
            step();
            bus.dl_wr = (c + 1 <= 3);
            bus.dl_addr = 16'(c + 1);
            bus.dl_data = 8'(8'h10 + c + 1);
            bus.dl_active = (c + 1 < 4);
            if (c + 1 >= 6) bus.cpu_req = 0;
        end
        bus.dl_wr = 0;
        repeat (3) step();

        // CPU write 0xA5 to 0x0100, then read it back.
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0100; bus.cpu_wdata = 8'hA5;
        smp();
        check("wr_cpu_ack", bus.cpu_ack, 1);
        step();
        bus.cpu_we = 0;
        smp();
        check("rd_cpu_ack", bus.cpu_ack, 1);
        check("wr_mem_en", bus.mem_en, 1);
        check("wr_mem_we", bus.mem_we, 1);
        check("wr_mem_addr", bus.mem_addr, 16'h0100);
        check("wr_mem_wdata", bus.mem_wdata, 8'hA5);
        cpu_q.push_back(8'hA5);
        step();
        bus.cpu_req = 0;
        smp();
        check("rd_mem_en", bus.mem_en, 1);
        check("rd_mem_we", bus.mem_we, 0);
        check("wr_no_valid_c2", bus.cpu_valid, 0);
        step(); smp();
        check("wr_no_valid_c3", bus.cpu_valid, 0);
        step(); smp();
        check("rd_cpu_valid", bus.cpu_valid, 1);
        repeat (2) step();

        // Reset in the cycle after a read grant: the read is dropped.
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h1234;
        smp();
        check("mid_cpu_ack", bus.cpu_ack, 1);
        step();
        bus.cpu_req = 0;
        reset = 1;
        smp();
        check_reset_state("midrst");
        step();
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            smp();
            check($sformatf("midrst_no_valid_%0d", i), bus.cpu_valid, 0);
            step();
        end

        check("vid_q_drained", vid_q.size(), 0);
        check("cpu_q_drained", cpu_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sorcerer_ram_arbiter.md
# sorcerer_ram_arbiter

Single-port main-RAM arbiter for the Sorcerer core, placed between the `sorcerer` machine and the synchronous system RAM. It shares one RAM port between three requesters: ioctl ROM/PAC/tape downloads, video character fetch, and Z80 CPU accesses. Downloads have absolute priority. Video and CPU alternate when both are pending. Read data returns on a fixed pipeline, tagged back to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 8, RAM data width

Ports:
- clk_sys  in  1  system clock; every register is clocked on its rising edge
- reset  in  1  asynchronous, active-high reset
- dl_active  in  1  download in progress (ioctl_download)
- dl_wr  in  1  one-cycle download write strobe (ioctl_wr)
- dl_addr  in  ADDR_W  download address
- dl_data  in  DATA_W  download byte
- dl_wait  out  1  download hold buffer full; drives ioctl_wait
- vid_req  in  1  video read request, level-held until vid_ack
- vid_addr  in  ADDR_W  video read address
- vid_ack  out  1  grant pulse; vid_addr is sampled in this cycle
- vid_valid  out  1  one-cycle pulse; vid_rdata is valid
- vid_rdata  out  DATA_W  video read data
- cpu_req  in  1  CPU request, level-held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  grant pulse; cpu_addr, cpu_we and cpu_wdata are sampled in this cycle
- cpu_valid  out  1  one-cycle pulse for reads only
- cpu_rdata  out  DATA_W  CPU read data
- mem_en  out  1  RAM access enable, registered
- mem_we  out  1  RAM write enable, registered
- mem_addr  out  ADDR_W  RAM address, registered
- mem_wdata  out  DATA_W  RAM write data, registered
- mem_rdata  in  DATA_W  synchronous RAM output, valid one cycle after mem_en

## Operation
- Download hold buffer:
  - One entry (addr, data, full flag).
  - dl_wr loads the buffer and sets full.
  - dl_wait = full.
  - A dl_wr that arrives while full is a protocol violation: it overwrites the entry and needs no other handling.
- Arbitration is evaluated every cycle, and at most one grant is issued per cycle:
  1. Hold buffer full: grant the download write. The buffer clears in the same cycle. No vid_ack or cpu_ack is issued.
  2. Otherwise, if dl_active = 1: grant nothing. The CPU and video requesters stall while a download is running.
  3. Otherwise, if vid_req and cpu_req are both pending: grant the requester that was not served last. The last_gnt register is 0 = vid, 1 = cpu.
  4. Otherwise, grant whichever single requester is pending.
- last_gnt updates only on vid or cpu grants. Download grants leave it unchanged.
- Grant cycle N: the selected ack pulses. The mem_* registers load in cycle N, so mem_en, mem_we, mem_addr and mem_wdata are visible in cycle N+1.
- A cycle with no grant leaves mem_en = 0 and mem_we = 0 in the next cycle. mem_addr and mem_wdata hold their previous values.
- Read tag pipeline: a 2-stage shift of {vid_rd, cpu_rd}. cpu_rd is set only when cpu_we = 0.
- In cycle N+2, mem_rdata is captured into the tagged requester's rdata register. The matching valid pulses in cycle N+3.
- rdata registers hold their value until the next read for the same requester.
- Writes (CPU or download) produce no valid pulse.
- Download writes always use mem_we = 1.
- A falling dl_active edge does not discard a full hold buffer. The buffer still drains at priority 1.

## Timing
- Reset values (asynchronous on reset high):
  - All acks, valids, dl_wait, mem_en and mem_we = 0.
  - mem_addr, mem_wdata, vid_rdata and cpu_rdata = 0.
  - Hold buffer empty, tag pipeline cleared, last_gnt = 1 (video wins the first contention).
- Reset mid-operation: reads already in flight are dropped and no valid pulses follow. A buffered download byte is lost.
- Acks are combinational from registered state plus the req inputs. A requester must deassert req, or present its next request, in the cycle after its ack.
- Read latency: valid is asserted 3 cycles after the ack cycle.
- Throughput:
  - One access per cycle in total.
  - Under continuous contention, video and CPU each receive every second cycle.
  - A back-to-back dl_wr every cycle is throttled by dl_wait. The sustained rate is one write per cycle once the buffer drains in the same cycle it is granted.
- A dl_wr in the same cycle the buffer drains loads the new entry. Full stays 1.

## Test plan
- Reset then idle: all outputs 0; mem_en remains 0 for 10 cycles with no requests.
- Solo CPU read: RAM preloaded with 0x5A at 0x1234; cpu_req with addr 0x1234 at cycle 0 -> cpu_ack at 0, mem_en/mem_addr = 0x1234 at 1, cpu_valid with cpu_rdata = 0x5A at 3, no vid_valid.
- Contention: vid_req and cpu_req held for 6 cycles -> grants alternate vid, cpu, vid, cpu…; each valid pulse carries the data from that requester's own address.
- Download burst: dl_active = 1, dl_wr to 0x0000..0x0003 with data 0x10..0x13 while cpu_req is held -> four mem_we writes with matching addr/data; no cpu_ack until dl_active = 0, then cpu_ack the next cycle.
- CPU write then read: write 0xA5 to 0x0100, then read 0x0100 -> no cpu_valid for the write; read returns 0xA5 with cpu_valid 3 cycles after its ack.
- Reset mid-read: reset asserted in cycle N+1 after a cpu_ack -> no cpu_valid ever; outputs return to reset values immediately.
